// File: rtl/spi_master_tx16.sv
// SPI mode-0 master transmitter: sends one DATA_WIDTH-bit word MSB-first with
// CS setup, hold and a minimum deselect gap, plus a start/busy/done handshake.
`timescale 1ns/1ps

module spi_master_tx16 #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  spi_sclk,
  output logic                  spi_cs_n,
  output logic                  spi_mosi
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [15:0]      HALF_MAX = 16'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wrap;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap    = (cnt_q == HALF_MAX);

    if (state_q != IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LEAD;
          shreg_d = tx_data;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      LEAD: begin
        if (wrap) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (wrap) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: advance MOSI except after the last bit, which holds.
            sclk_d = 1'b0;
            bit_d  = bit_q + BIT_W'(1);
            if (bit_q == LAST_BIT) begin
              state_d = TRAIL;
            end else begin
              shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      TRAIL: begin
        if (wrap) begin
          state_d = GAP;
          cs_n_d  = 1'b1;
          shreg_d = '0;
        end
      end
      GAP: begin
        if (wrap) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // MOSI is the shift register MSB, so it is a flop output like the rest.
  assign spi_mosi = shreg_q[DATA_WIDTH-1];
  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_master_tx16.sv
// Directed bench for spi_master_tx16: frame timing at CLK_DIV=4 and 2, loopback
// into a 2-flop-synchronised receiver model, ignored restarts, mid-frame reset, idle.
`timescale 1ns/1ps

module tb_spi_master_tx16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start4, start2;
  logic [15:0] tx4, tx2;
  logic        d4_busy, d4_done, d4_sclk, d4_cs_n, d4_mosi;
  logic        d2_busy, d2_done, d2_sclk, d2_cs_n, d2_mosi;

  int total = 0;
  int bad   = 0;

  bit   sel;
  logic m_busy, m_done, m_sclk, m_cs_n, m_mosi;

  int          mon_rises, mon_first_rise, mon_cs_fall, mon_cs_rise;
  int          mon_done_at, mon_done_count, mon_busy_cycles, mon_sclk_idle_bad;
  bit          mon_spacing_ok;
  logic [15:0] mon_word;

  always #5 clk = ~clk;

  spi_master_tx16 #(.CLK_DIV(4), .DATA_WIDTH(16)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .tx_data(tx4),
    .busy(d4_busy), .done(d4_done), .spi_sclk(d4_sclk),
    .spi_cs_n(d4_cs_n), .spi_mosi(d4_mosi)
  );

  spi_master_tx16 #(.CLK_DIV(2), .DATA_WIDTH(16)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .tx_data(tx2),
    .busy(d2_busy), .done(d2_done), .spi_sclk(d2_sclk),
    .spi_cs_n(d2_cs_n), .spi_mosi(d2_mosi)
  );

  assign m_busy = sel ? d2_busy : d4_busy;
  assign m_done = sel ? d2_done : d4_done;
  assign m_sclk = sel ? d2_sclk : d4_sclk;
  assign m_cs_n = sel ? d2_cs_n : d4_cs_n;
  assign m_mosi = sel ? d2_mosi : d4_mosi;

  // Receiver model on the CLK_DIV=4 instance: 2-flop sync plus edge register.
  logic [2:0]  rx_sclk_s, rx_cs_s;
  logic [1:0]  rx_mosi_s;
  logic [15:0] rx_shift;
  int          rx_bits;
  logic [15:0] rx_words[$];

  always @(posedge clk) begin
    if (reset) begin
      rx_sclk_s <= 3'b000;
      rx_cs_s   <= 3'b111;
      rx_mosi_s <= 2'b00;
      rx_shift  <= 16'h0;
      rx_bits   <= 0;
    end else begin
      rx_sclk_s <= {rx_sclk_s[1:0], d4_sclk};
      rx_cs_s   <= {rx_cs_s[1:0], d4_cs_n};
      rx_mosi_s <= {rx_mosi_s[0], d4_mosi};
      if (rx_cs_s[1] && !rx_cs_s[2]) begin
        if (rx_bits == 16) rx_words.push_back(rx_shift);
        rx_bits <= 0;
      end else if (rx_sclk_s[1] && !rx_sclk_s[2] && !rx_cs_s[1]) begin
        rx_shift <= {rx_shift[14:0], rx_mosi_s[1]};
        rx_bits  <= rx_bits + 1;
      end
    end
  end

  task automatic set_start(input bit s);
    if (sel) start2 = s; else start4 = s;
  endtask

  task automatic set_tx(input logic [15:0] d);
    if (sel) tx2 = d; else tx4 = d;
  endtask

  // Call at sample 0 (the negedge right after the accepting edge). Records
  // timing of the selected instance over one frame plus a trailing idle window.
  task automatic monitor_frame(input int d, input bit inject);
    int  last;
    bit  prev_sclk;
    mon_rises = 0; mon_first_rise = -1; mon_spacing_ok = 1; mon_word = 16'h0;
    mon_cs_fall = -1; mon_cs_rise = -1; mon_done_at = -1; mon_done_count = 0;
    mon_busy_cycles = 0; mon_sclk_idle_bad = 0;
    prev_sclk = 1'b0; last = -1;
    for (int n = 0; n <= 34 * d + 20; n++) begin
      if (m_busy) mon_busy_cycles++;
      if (!m_cs_n && mon_cs_fall < 0) mon_cs_fall = n;
      if (m_cs_n && mon_cs_fall >= 0 && mon_cs_rise < 0) mon_cs_rise = n;
      if (m_sclk && !prev_sclk) begin
        if (mon_first_rise < 0) mon_first_rise = n;
        else if (n - last != 2 * d) mon_spacing_ok = 0;
        last = n;
        mon_rises++;
        mon_word = {mon_word[14:0], m_mosi};
      end
      if (m_sclk && m_cs_n) mon_sclk_idle_bad++;
      if (m_done) begin
        mon_done_count++;
        if (mon_done_at < 0) mon_done_at = n;
      end
      prev_sclk = m_sclk;
      if (inject && (n == 9 || n == 49)) begin
        set_tx(16'hDEAD);
        set_start(1'b1);
      end else begin
        set_start(1'b0);
      end
      @(negedge clk);
    end
  endtask

  task automatic launch(input logic [15:0] d);
    set_tx(d);
    set_start(1'b1);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; start4 = 1'b0; start2 = 1'b0; tx4 = 16'h0; tx2 = 16'h0; sel = 1'b0;
    #3;
    total++;
    if ({d4_busy, d4_done, d4_sclk, d4_cs_n, d4_mosi} !== 5'b00010) begin
      bad++; $display("FAIL reset_dut4 got=%b exp=00010", {d4_busy, d4_done, d4_sclk, d4_cs_n, d4_mosi});
    end
    total++;
    if ({d2_busy, d2_done, d2_sclk, d2_cs_n, d2_mosi} !== 5'b00010) begin
      bad++; $display("FAIL reset_dut2 got=%b exp=00010", {d2_busy, d2_done, d2_sclk, d2_cs_n, d2_mosi});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_div4;
    sel = 1'b0;
    launch(16'hA5C3);
    monitor_frame(4, 1'b0);
    total++; if (mon_cs_fall !== 0) begin bad++; $display("FAIL t1_cs_fall got=%0d exp=0", mon_cs_fall); end
    total++; if (mon_rises !== 16) begin bad++; $display("FAIL t1_rises got=%0d exp=16", mon_rises); end
    total++; if (mon_first_rise !== 4) begin bad++; $display("FAIL t1_first_rise got=%0d exp=4", mon_first_rise); end
    total++; if (mon_spacing_ok !== 1'b1) begin bad++; $display("FAIL t1_spacing got=irregular exp=8"); end
    total++; if (mon_word !== 16'hA5C3) begin bad++; $display("FAIL t1_word got=%h exp=a5c3", mon_word); end
    total++; if (mon_cs_rise !== 132) begin bad++; $display("FAIL t1_cs_rise got=%0d exp=132", mon_cs_rise); end
    total++; if (mon_done_at !== 136) begin bad++; $display("FAIL t1_done_at got=%0d exp=136", mon_done_at); end
    total++; if (mon_done_count !== 1) begin bad++; $display("FAIL t1_done_count got=%0d exp=1", mon_done_count); end
    total++; if (mon_busy_cycles !== 136) begin bad++; $display("FAIL t1_busy got=%0d exp=136", mon_busy_cycles); end
    total++; if (mon_sclk_idle_bad !== 0) begin bad++; $display("FAIL t1_sclk_cs_high got=%0d exp=0", mon_sclk_idle_bad); end
    total++; if ({d4_cs_n, d4_mosi, d4_sclk} !== 3'b100) begin bad++; $display("FAIL t1_idle_after got=%b exp=100", {d4_cs_n, d4_mosi, d4_sclk}); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] words[4];
    int run, min_gap, gaps;
    bit seen_low, got;
    words[0] = 16'h0000; words[1] = 16'hFFFF; words[2] = 16'h8001; words[3] = 16'h1234;
    sel = 1'b0;
    rx_words.delete();
    run = 0; min_gap = 1000; gaps = 0; seen_low = 0;
    launch(words[0]);
    for (int w = 0; w < 4; w++) begin
      got = 0;
      for (int n = 0; n < 200 && !got; n++) begin
        set_start(1'b0);
        if (d4_cs_n) run++;
        else begin
          if (seen_low && run > 0) begin
            gaps++;
            if (run < min_gap) min_gap = run;
          end
          run = 0;
          seen_low = 1;
        end
        if (d4_done) begin
          got = 1;
          if (w < 3) begin
            set_tx(words[w+1]);
            set_start(1'b1);
          end
        end
        @(negedge clk);
      end
      total++; if (!got) begin bad++; $display("FAIL t2_done_timeout word=%0d got=none exp=done", w); end
    end
    set_start(1'b0);
    repeat (10) @(negedge clk);
    total++; if (rx_words.size() !== 4) begin bad++; $display("FAIL t2_rx_count got=%0d exp=4", rx_words.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < rx_words.size()) begin
        total++;
        if (rx_words[i] !== words[i]) begin bad++; $display("FAIL t2_rx_word%0d got=%h exp=%h", i, rx_words[i], words[i]); end
      end
    end
    total++; if (gaps !== 3 || min_gap < 5) begin bad++; $display("FAIL t2_cs_gap got=gaps%0d_min%0d exp=gaps3_min5", gaps, min_gap); end
  endtask

  task automatic test_start_while_busy;
    sel = 1'b0;
    launch(16'h3C96);
    monitor_frame(4, 1'b1);
    total++; if (mon_word !== 16'h3C96) begin bad++; $display("FAIL t3_word got=%h exp=3c96", mon_word); end
    total++; if (mon_rises !== 16) begin bad++; $display("FAIL t3_rises got=%0d exp=16", mon_rises); end
    total++; if (mon_done_count !== 1) begin bad++; $display("FAIL t3_done_count got=%0d exp=1", mon_done_count); end
    total++; if (mon_done_at !== 136) begin bad++; $display("FAIL t3_done_at got=%0d exp=136", mon_done_at); end
    total++; if (mon_busy_cycles !== 136) begin bad++; $display("FAIL t3_busy got=%0d exp=136", mon_busy_cycles); end
  endtask

  task automatic test_reset_mid_frame;
    int done_seen;
    sel = 1'b0;
    launch(16'h1234);
    set_start(1'b0);
    repeat (40) @(negedge clk);
    total++; if (d4_cs_n !== 1'b0 || d4_busy !== 1'b1) begin bad++; $display("FAIL t4_mid_frame got=cs%b_busy%b exp=cs0_busy1", d4_cs_n, d4_busy); end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({d4_busy, d4_done, d4_sclk, d4_cs_n, d4_mosi} !== 5'b00010) begin
      bad++; $display("FAIL t4_async got=%b exp=00010", {d4_busy, d4_done, d4_sclk, d4_cs_n, d4_mosi});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 150; n++) begin
      if (d4_done || !d4_cs_n || d4_busy) done_seen++;
      @(negedge clk);
    end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL t4_after_release got=%0d_active exp=0", done_seen); end
    launch(16'h00FF);
    monitor_frame(4, 1'b0);
    total++; if (mon_word !== 16'h00FF) begin bad++; $display("FAIL t4_word got=%h exp=00ff", mon_word); end
    total++; if (mon_rises !== 16) begin bad++; $display("FAIL t4_rises got=%0d exp=16", mon_rises); end
    total++; if (mon_done_at !== 136) begin bad++; $display("FAIL t4_done_at got=%0d exp=136", mon_done_at); end
  endtask

  task automatic test_div2;
    sel = 1'b1;
    launch(16'h5555);
    monitor_frame(2, 1'b0);
    total++; if (mon_first_rise !== 2) begin bad++; $display("FAIL t5_first_rise got=%0d exp=2", mon_first_rise); end
    total++; if (mon_spacing_ok !== 1'b1) begin bad++; $display("FAIL t5_spacing got=irregular exp=4"); end
    total++; if (mon_rises !== 16) begin bad++; $display("FAIL t5_rises got=%0d exp=16", mon_rises); end
    total++; if (mon_word !== 16'h5555) begin bad++; $display("FAIL t5_word got=%h exp=5555", mon_word); end
    total++; if (mon_done_at !== 68) begin bad++; $display("FAIL t5_done_at got=%0d exp=68", mon_done_at); end
    total++; if (mon_busy_cycles !== 68) begin bad++; $display("FAIL t5_busy got=%0d exp=68", mon_busy_cycles); end
    sel = 1'b0;
  endtask

  task automatic test_idle;
    int viol4, viol2;
    start4 = 1'b0; start2 = 1'b0;
    viol4 = 0; viol2 = 0;
    for (int n = 0; n < 200; n++) begin
      if ({d4_busy, d4_done, d4_sclk, d4_cs_n, d4_mosi} !== 5'b00010) viol4++;
      if ({d2_busy, d2_done, d2_sclk, d2_cs_n, d2_mosi} !== 5'b00010) viol2++;
      @(negedge clk);
    end
    total++; if (viol4 !== 0) begin bad++; $display("FAIL t6_idle_dut4 got=%0d exp=0", viol4); end
    total++; if (viol2 !== 0) begin bad++; $display("FAIL t6_idle_dut2 got=%0d exp=0", viol2); end
  endtask

  initial begin
    test_reset();
    test_frame_div4();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_frame();
    test_div2();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
